// File: rtl/msi_cpu_requester.sv
// MSI snooping-protocol CPU-side requester for a single cache block.
// Issues bus transactions for CPU accesses and tracks the block's coherence state.
module msi_cpu_requester #(
  parameter int TAG_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cpu_valid,
  input  logic             cpu_write,
  input  logic [TAG_W-1:0] cpu_tag,
  output logic             cpu_ready,
  output logic             cpu_done,
  output logic             bus_req,
  input  logic             bus_grant,
  output logic [1:0]       bus_op,
  output logic [TAG_W-1:0] bus_tag,
  output logic             bus_wb,
  input  logic             snoop_downgrade,
  input  logic             snoop_invalidate,
  output logic [1:0]       state,
  output logic [TAG_W-1:0] tag
);

  typedef enum logic [1:0] {
    C_IDLE = 2'd0,
    C_WB   = 2'd1,
    C_REQ  = 2'd2
  } ctl_e;

  localparam logic [1:0] ST_I = 2'b00;
  localparam logic [1:0] ST_E = 2'b01;
  localparam logic [1:0] ST_S = 2'b10;

  localparam logic [1:0] OP_RM   = 2'b00;
  localparam logic [1:0] OP_WM   = 2'b01;
  localparam logic [1:0] OP_INV  = 2'b10;
  localparam logic [1:0] OP_NONE = 2'b11;

  ctl_e             ctl_q, ctl_d;
  logic [1:0]       state_q, state_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [1:0]       op_q, op_d;
  logic [TAG_W-1:0] ltag_q, ltag_d;
  logic             done_q, done_d;
  logic             bus_req_q, bus_req_d;
  logic             bus_wb_q, bus_wb_d;
  logic [1:0]       bus_op_q, bus_op_d;
  logic [TAG_W-1:0] bus_tag_q, bus_tag_d;

  logic grant;
  logic hit;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ctl_q     <= C_IDLE;
      state_q   <= ST_I;
      tag_q     <= '0;
      op_q      <= OP_NONE;
      ltag_q    <= '0;
      done_q    <= 1'b0;
      bus_req_q <= 1'b0;
      bus_wb_q  <= 1'b0;
      bus_op_q  <= OP_NONE;
      bus_tag_q <= '0;
    end else begin
      ctl_q     <= ctl_d;
      state_q   <= state_d;
      tag_q     <= tag_d;
      op_q      <= op_d;
      ltag_q    <= ltag_d;
      done_q    <= done_d;
      bus_req_q <= bus_req_d;
      bus_wb_q  <= bus_wb_d;
      bus_op_q  <= bus_op_d;
      bus_tag_q <= bus_tag_d;
    end
  end

  always_comb begin
    ctl_d   = ctl_q;
    state_d = state_q;
    tag_d   = tag_q;
    op_d    = op_q;
    ltag_d  = ltag_q;
    done_d  = 1'b0;
    grant   = bus_grant & bus_req_q;
    hit     = (state_q != ST_I) && (tag_q == cpu_tag);

    // a granted transaction owns the block this cycle; snoops are dropped
    if (!grant) begin
      if (snoop_invalidate) begin
        state_d = ST_I;
      end else if (snoop_downgrade && state_q == ST_E) begin
        state_d = ST_S;
      end
    end

    unique case (ctl_q)
      C_IDLE: begin
        if (cpu_valid) begin
          ltag_d = cpu_tag;
          if (hit && (!cpu_write || state_q == ST_E)) begin
            done_d = 1'b1;
          end else if (hit) begin
            op_d  = OP_INV;
            ctl_d = C_REQ;
          end else begin
            op_d  = cpu_write ? OP_WM : OP_RM;
            ctl_d = (state_q == ST_E) ? C_WB : C_REQ;
          end
        end
      end
      C_WB: begin
        if (grant) begin
          state_d = ST_I;
          ctl_d   = C_REQ;
        end else if (snoop_invalidate || snoop_downgrade ||
                     state_q != ST_E) begin
          // victim is clean now: skip the write-back
          ctl_d = C_REQ;
        end
      end
      C_REQ: begin
        if (grant) begin
          tag_d   = ltag_q;
          state_d = (op_q == OP_RM) ? ST_S : ST_E;
          done_d  = 1'b1;
          ctl_d   = C_IDLE;
        end else if (op_q == OP_INV &&
                     (snoop_invalidate || state_q == ST_I)) begin
          // lost our shared copy: upgrade must fetch the block
          op_d = OP_WM;
        end
      end
      default: ctl_d = C_IDLE;
    endcase

    bus_req_d = (ctl_d != C_IDLE);
    bus_wb_d  = (ctl_d == C_WB);
    bus_op_d  = (ctl_d == C_REQ) ? op_d : OP_NONE;
    bus_tag_d = bus_tag_q;
    if (ctl_d == C_WB) begin
      bus_tag_d = tag_q;
    end else if (ctl_d == C_REQ) begin
      bus_tag_d = ltag_d;
    end
  end

  assign cpu_ready = (ctl_q == C_IDLE);
  assign cpu_done  = done_q;
  assign bus_req   = bus_req_q;
  assign bus_wb    = bus_wb_q;
  assign bus_op    = bus_op_q;
  assign bus_tag   = bus_tag_q;
  assign state     = state_q;
  assign tag       = tag_q;

endmodule

// File: tb/tb_msi_cpu_requester.sv
// Directed bench for msi_cpu_requester; expected bus
// transactions and completions are queued and checked by a monitor.
module tb_msi_cpu_requester;

  logic       clock;
  logic       reset;
  logic       cpu_valid;
  logic       cpu_write;
  logic [7:0] cpu_tag;
  logic       cpu_ready;
  logic       cpu_done;
  logic       bus_req;
  logic       bus_grant;
  logic [1:0] bus_op;
  logic [7:0] bus_tag;
  logic       bus_wb;
  logic       snoop_downgrade;
  logic       snoop_invalidate;
  logic [1:0] state;
  logic [7:0] tag;

  int vectors;
  int miscompares;

  typedef struct {
    bit         is_bus;
    logic [1:0] op;
    logic [7:0] tg;
    logic       wb;
    logic [1:0] st;
  } exp_t;

  exp_t q[$];

  msi_cpu_requester #(.TAG_W(8)) dut (
    .clock           (clock),
    .reset           (reset),
    .cpu_valid       (cpu_valid),
    .cpu_write       (cpu_write),
    .cpu_tag         (cpu_tag),
    .cpu_ready       (cpu_ready),
    .cpu_done        (cpu_done),
    .bus_req         (bus_req),
    .bus_grant       (bus_grant),
    .bus_op          (bus_op),
    .bus_tag         (bus_tag),
    .bus_wb          (bus_wb),
    .snoop_downgrade (snoop_downgrade),
    .snoop_invalidate(snoop_invalidate),
    .state           (state),
    .tag             (tag)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_bus(input logic [1:0] op, input logic [7:0] tg,
                          input logic wb);
    exp_t e;
    e.is_bus = 1'b1;
    e.op = op;
    e.tg = tg;
    e.wb = wb;
    e.st = 2'b00;
    q.push_back(e);
  endtask

  task automatic push_done(input logic [1:0] st, input logic [7:0] tg);
    exp_t e;
    e.is_bus = 1'b0;
    e.op = 2'b11;
    e.tg = tg;
    e.wb = 1'b0;
    e.st = st;
    q.push_back(e);
  endtask

  // monitor: pop one expectation per granted transaction or completion
  always @(negedge clock) begin
    if (!reset) begin
      if (bus_req && bus_grant) begin
        if (q.size() == 0 || !q[0].is_bus) begin
          chk("unexpected_bus", {bus_op, bus_tag}, 32'hffff);
        end else begin
          chk("bus_op", bus_op, q[0].op);
          chk("bus_tag", bus_tag, q[0].tg);
          chk("bus_wb", bus_wb, q[0].wb);
          void'(q.pop_front());
        end
      end
      if (cpu_done) begin
        if (q.size() == 0 || q[0].is_bus) begin
          chk("unexpected_done", cpu_done, 0);
        end else begin
          chk("done_state", state, q[0].st);
          chk("done_tag", tag, q[0].tg);
          void'(q.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic cpu_req(input logic wr, input logic [7:0] tg);
    int n;
    n = 0;
    while (!cpu_ready && n < 50) begin
      tick();
      n++;
    end
    if (!cpu_ready) chk("ready_timeout", cpu_ready, 1);
    cpu_valid = 1'b1;
    cpu_write = wr;
    cpu_tag = tg;
    tick();
    cpu_valid = 1'b0;
  endtask

  task automatic grant_after(input int n);
    int k;
    k = 0;
    while (!bus_req && k < 50) begin
      tick();
      k++;
    end
    if (!bus_req) chk("req_timeout", bus_req, 1);
    repeat (n) tick();
    bus_grant = 1'b1;
    tick();
    bus_grant = 1'b0;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    reset = 1'b1;
    cpu_valid = 1'b0;
    cpu_write = 1'b0;
    cpu_tag = 8'h00;
    bus_grant = 1'b0;
    snoop_downgrade = 1'b0;
    snoop_invalidate = 1'b0;
    repeat (2) tick();
    chk("rst_state", state, 0);
    chk("rst_tag", tag, 0);
    chk("rst_req", bus_req, 0);
    chk("rst_op", bus_op, 3);
    chk("rst_ready", cpu_ready, 1);
    chk("rst_done", cpu_done, 0);
    reset = 1'b0;
    tick();

    // 1: read miss from INVALID
    push_bus(2'b00, 8'h12, 1'b0);
    push_done(2'b10, 8'h12);
    cpu_req(1'b0, 8'h12);
    chk("t1_req", bus_req, 1);
    chk("t1_op", bus_op, 0);
    chk("t1_tag", bus_tag, 8'h12);
    grant_after(3);
    chk("t1_done", cpu_done, 1);
    chk("t1_req_drop", bus_req, 0);
    tick();

    // 2: upgrade from SHARED, then write hit in EXCLUSIVE
    push_bus(2'b10, 8'h12, 1'b0);
    push_done(2'b01, 8'h12);
    cpu_req(1'b1, 8'h12);
    chk("t2_op", bus_op, 2);
    grant_after(1);
    tick();
    push_done(2'b01, 8'h12);
    cpu_req(1'b1, 8'h12);
    chk("t2_hit_done", cpu_done, 1);
    chk("t2_hit_noreq", bus_req, 0);
    tick();
    bus_grant = 1'b1;
    tick();
    bus_grant = 1'b0;
    chk("t2_stray_grant", state, 1);

    // 3: dirty victim write-back then read miss
    push_bus(2'b11, 8'h12, 1'b1);
    push_bus(2'b00, 8'h34, 1'b0);
    push_done(2'b10, 8'h34);
    cpu_req(1'b0, 8'h34);
    chk("t3_wb", bus_wb, 1);
    chk("t3_wb_tag", bus_tag, 8'h12);
    grant_after(0);
    chk("t3_state_i", state, 0);
    chk("t3_wb_drop", bus_wb, 0);
    grant_after(1);
    tick();

    // 4: upgrade raced by remote invalidate
    push_bus(2'b00, 8'h12, 1'b0);
    push_done(2'b10, 8'h12);
    cpu_req(1'b0, 8'h12);
    grant_after(0);
    tick();
    push_bus(2'b01, 8'h12, 1'b0);
    push_done(2'b01, 8'h12);
    cpu_req(1'b1, 8'h12);
    chk("t4_op_inv", bus_op, 2);
    snoop_invalidate = 1'b1;
    tick();
    snoop_invalidate = 1'b0;
    chk("t4_op_wm", bus_op, 1);
    chk("t4_req_held", bus_req, 1);
    chk("t4_state_i", state, 0);
    grant_after(1);
    tick();

    // 5: snoops on EXCLUSIVE block, then read miss
    snoop_downgrade = 1'b1;
    tick();
    snoop_downgrade = 1'b0;
    chk("t5_down", state, 2);
    snoop_invalidate = 1'b1;
    tick();
    snoop_invalidate = 1'b0;
    chk("t5_inv", state, 0);
    push_bus(2'b00, 8'h12, 1'b0);
    push_done(2'b10, 8'h12);
    cpu_req(1'b0, 8'h12);
    chk("t5_op", bus_op, 0);
    chk("t5_wb", bus_wb, 0);
    grant_after(2);
    tick();

    // 6: reset while requesting
    cpu_req(1'b0, 8'h56);
    chk("t6_req", bus_req, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_req_drop", bus_req, 0);
    chk("t6_op", bus_op, 3);
    chk("t6_state", state, 0);
    chk("t6_ready", cpu_ready, 1);
    tick();
    reset = 1'b0;
    repeat (5) tick();
    chk("t6_no_done", cpu_done, 0);

    for (int i = 0; i < 20 && q.size() != 0; i++) tick();
    chk("drain", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
